fpu_slow_dispatch: RTL and testbench
====================================

FPU_SLOW_DISPATCH -- requirements
Module: fpu_slow_dispatch

Interface
REQ-001 Parameter N_CH, default 2 (range 1..8): number of slow-FPU channels.
REQ-002 Parameter N_CHK, default 3: number of register-hazard check ports.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 issue_valid  input  1  slow FPU op presented for dispatch.
REQ-006 issue_rd  input  5  destination FP register of presented op.
REQ-007 issue_ready  output  1  op accepted this cycle when high with issue_valid.
REQ-008 ch_en  output  N_CH  one-cycle start pulse, one-hot, per channel.
REQ-009 ch_valid  input  N_CH  per-channel result-valid pulse.
REQ-010 ch_result  input  32*N_CH  per-channel result; channel i at bits [32*i+31:32*i].
REQ-011 wb_valid  output  1  head result available for writeback.
REQ-012 wb_rd / wb_data  output  5 / 32  writeback register and value.
REQ-013 wb_ready  input  1  writeback consumed (low while stall_w).
REQ-014 flush  input  1  abort all in-flight ops.
REQ-015 chk_rd  input  5*N_CHK  source registers to check; chk_hit  output  N_CHK  hazard per port.
REQ-016 inflight  output  $clog2(N_CH+1)  count of BUSY+DONE channels.

Function
REQ-017 Each channel SHALL hold state IDLE, BUSY, DONE or DRAIN plus a 5-bit rd and 32-bit result register.
REQ-018 Allocation SHALL be strict round-robin: tail pointer names the only channel eligible for issue; head pointer names the oldest op.
REQ-019 issue_ready SHALL equal (channel[tail] == IDLE) and not flush; combinational, independent of issue_valid.
REQ-020 On issue_valid & issue_ready: ch_en[tail] pulses that cycle, channel goes BUSY, rd latched, tail advances modulo N_CH.
REQ-021 BUSY channel with ch_valid: result latched, state DONE next cycle; ch_valid on IDLE or DONE channel SHALL be ignored.
REQ-022 wb_valid SHALL be high iff channel[head] == DONE; wb_rd/wb_data from that channel, 0 when wb_valid low.
REQ-023 On wb_valid & wb_ready: channel[head] goes IDLE, head advances modulo N_CH; retirement is strictly in issue order.
REQ-024 Same-cycle issue and retire SHALL both take effect; a channel freed by retire is not issuable until next cycle.
REQ-025 flush: BUSY channels go DRAIN, DONE channels go IDLE, head and tail reset to 0 next cycle; same-cycle issue blocked.
REQ-026 DRAIN channel with ch_valid goes IDLE, result discarded; DRAIN channels SHALL stall issue (REQ-019) until drained.
REQ-027 chk_hit[k] SHALL be high iff any BUSY or DONE channel holds rd == chk_rd[k]; f0 is a normal register.
REQ-028 Dispatch latency: ch_en same cycle as acceptance; wb_valid no earlier than one cycle after ch_valid (see REQ-032).

Reset
REQ-029 On rst low: all channels IDLE, head = tail = 0, result/rd registers 0.
REQ-030 During reset: ch_en = 0, wb_valid = 0, wb_rd = 0, wb_data = 0, chk_hit = 0, inflight = 0, issue_ready = 0.
REQ-031 Reset mid-operation SHALL discard in-flight ops; later ch_valid pulses are ignored per REQ-021.

Configuration
REQ-032 Macro FPU_SLOW_DISPATCH_BYPASS_EN defined: if channel[head] is BUSY and ch_valid[head] high, wb_valid asserts that same cycle with ch_result forwarded; retire on wb_ready goes straight to IDLE, otherwise DONE.
REQ-033 Macro undefined: no bypass; wb_valid only from DONE state, one cycle after ch_valid.

Structure
REQ-034 Shared package fpu_pkg SHALL hold the channel-state enum, FP register width (5) and data width (32) constants.
REQ-035 One sub-module fpu_dispatch_chan (per-channel state machine and result register) SHALL be instantiated N_CH times; pointers, writeback mux and hazard compare stay in the top.

Verification
REQ-036 N_CH=2: issue rd=3, ch_valid[0] 4 cycles later with 0x3F800000, wb_ready=1 -> wb_valid, wb_rd=3, wb_data=0x3F800000 one cycle after ch_valid (bypass off).
REQ-037 Issue rd=1 (ch0) then rd=2 (ch1); ch_valid[1] before ch_valid[0] -> writeback order rd=1 then rd=2.
REQ-038 Both channels BUSY, third issue_valid -> issue_ready=0, inflight=2, chk_rd=1 gives chk_hit=1, chk_rd=5 gives 0.
REQ-039 flush with ch0 BUSY -> next cycle head=tail=0, issue_ready=0 until ch_valid[0], that result never on wb.
REQ-040 wb_ready=0 for 3 cycles with head DONE -> wb_valid held, wb_data stable, no retire.
REQ-041 rst low with ch1 BUSY, release, ch_valid[1] pulse -> ignored, wb_valid stays 0, inflight=0.

Source files
------------

// File: rtl/fpu_pkg.sv
// fpu_pkg: shared types and widths for the slow-FPU dispatch block.
package fpu_pkg;

    localparam int unsigned FP_REG_W = 5;
    localparam int unsigned DATA_W   = 32;

    typedef enum logic [1:0] {
        CH_IDLE  = 2'd0,
        CH_BUSY  = 2'd1,
        CH_DONE  = 2'd2,
        CH_DRAIN = 2'd3
    } ch_state_e;

endpackage

// File: rtl/fpu_dispatch_chan.sv
// fpu_dispatch_chan: one slow-FPU channel -- state machine plus rd/result holding registers.
// Optional feature: FPU_SLOW_DISPATCH_BYPASS_EN lets a BUSY head channel retire on the
// same cycle its result arrives.
module fpu_dispatch_chan
    import fpu_pkg::*;
(
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_start,
    input  logic [FP_REG_W-1:0] i_rd,
    input  logic                i_valid,
    input  logic [DATA_W-1:0]   i_result,
    input  logic                i_retire,
    input  logic                i_flush,
    output ch_state_e           o_state,
    output logic [FP_REG_W-1:0] o_rd,
    output logic [DATA_W-1:0]   o_result
);

    ch_state_e           r_state;
    ch_state_e           w_state_nxt;
    logic [FP_REG_W-1:0] r_rd;
    logic [DATA_W-1:0]   r_result;

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= CH_IDLE;
        else          r_state <= w_state_nxt;
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            CH_IDLE: begin
                if (i_start) w_state_nxt = CH_BUSY;
            end
            CH_BUSY: begin
                // A result landing in the flush cycle completes the aborted op, so there is
                // nothing left to drain; waiting for a second pulse would hang the channel.
                if (i_flush) begin
                    w_state_nxt = i_valid ? CH_IDLE : CH_DRAIN;
                end else if (i_valid) begin
`ifdef FPU_SLOW_DISPATCH_BYPASS_EN
                    w_state_nxt = i_retire ? CH_IDLE : CH_DONE;
`else
                    w_state_nxt = CH_DONE;
`endif
                end
            end
            CH_DONE: begin
                if (i_flush || i_retire) w_state_nxt = CH_IDLE;
            end
            CH_DRAIN: begin
                if (i_valid) w_state_nxt = CH_IDLE;
            end
            default: w_state_nxt = CH_IDLE;
        endcase
    end

    // Capture destination register on issue and result on completion.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rd     <= '0;
            r_result <= '0;
        end else begin
            if (i_start && (r_state == CH_IDLE)) r_rd <= i_rd;
            if ((r_state == CH_BUSY) && i_valid && !i_flush) r_result <= i_result;
        end
    end

    assign o_state  = r_state;
    assign o_rd     = r_rd;
    assign o_result = r_result;

endmodule

// File: rtl/fpu_slow_dispatch.sv
// fpu_slow_dispatch: round-robin dispatch of slow FPU ops over N_CH channels with in-order
// writeback, flush/drain handling and register-hazard checks.
// Optional feature: FPU_SLOW_DISPATCH_BYPASS_EN forwards a head channel's result to writeback
// in the cycle it arrives.
module fpu_slow_dispatch
    import fpu_pkg::*;
#(
    parameter int unsigned N_CH  = 2,
    parameter int unsigned N_CHK = 3
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        issue_valid,
    input  logic [FP_REG_W-1:0]         issue_rd,
    output logic                        issue_ready,
    output logic [N_CH-1:0]             ch_en,
    input  logic [N_CH-1:0]             ch_valid,
    input  logic [DATA_W*N_CH-1:0]      ch_result,
    output logic                        wb_valid,
    output logic [FP_REG_W-1:0]         wb_rd,
    output logic [DATA_W-1:0]           wb_data,
    input  logic                        wb_ready,
    input  logic                        flush,
    input  logic [FP_REG_W*N_CHK-1:0]   chk_rd,
    output logic [N_CHK-1:0]            chk_hit,
    output logic [$clog2(N_CH+1)-1:0]   inflight
);

    localparam int unsigned PTR_W = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int unsigned CNT_W = $clog2(N_CH + 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(N_CH - 1);

    logic [PTR_W-1:0]    r_head;
    logic [PTR_W-1:0]    r_tail;
    ch_state_e           w_state [N_CH];
    logic [FP_REG_W-1:0] w_rd    [N_CH];
    logic [DATA_W-1:0]   w_res   [N_CH];
    logic [DATA_W-1:0]   w_lane  [N_CH];
    logic                w_accept;
    logic                w_retire;
    logic [N_CH-1:0]     w_retire_vec;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
        assign w_lane[gi] = ch_result[DATA_W*gi +: DATA_W];

        fpu_dispatch_chan u_chan (
            .i_clk    (clk),
            .i_rst_n  (rst),
            .i_start  (ch_en[gi]),
            .i_rd     (issue_rd),
            .i_valid  (ch_valid[gi]),
            .i_result (w_lane[gi]),
            .i_retire (w_retire_vec[gi]),
            .i_flush  (flush),
            .o_state  (w_state[gi]),
            .o_rd     (w_rd[gi]),
            .o_result (w_res[gi])
        );
    end

    // Issue acceptance: only the tail channel may take a new op.
    always_comb begin
        issue_ready = rst && (w_state[r_tail] == CH_IDLE) && !flush;
        w_accept    = issue_valid && issue_ready;
        ch_en       = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (w_accept && (r_tail == PTR_W'(i))) ch_en[i] = 1'b1;
        end
    end

    // Writeback mux from the head channel and per-channel retire strobe.
    always_comb begin
        wb_valid = 1'b0;
        wb_rd    = '0;
        wb_data  = '0;
        if (w_state[r_head] == CH_DONE) begin
            wb_valid = 1'b1;
            wb_rd    = w_rd[r_head];
            wb_data  = w_res[r_head];
        end
`ifdef FPU_SLOW_DISPATCH_BYPASS_EN
        else if ((w_state[r_head] == CH_BUSY) && ch_valid[r_head]) begin
            wb_valid = 1'b1;
            wb_rd    = w_rd[r_head];
            wb_data  = w_lane[r_head];
        end
`endif
        w_retire     = wb_valid && wb_ready;
        w_retire_vec = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (w_retire && (r_head == PTR_W'(i))) w_retire_vec[i] = 1'b1;
        end
    end

    // Hazard compare and in-flight count over BUSY/DONE channels.
    always_comb begin
        chk_hit  = '0;
        inflight = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            if ((w_state[i] == CH_BUSY) || (w_state[i] == CH_DONE)) begin
                inflight = inflight + CNT_W'(1);
                for (int unsigned k = 0; k < N_CHK; k++) begin
                    if (w_rd[i] == chk_rd[FP_REG_W*k +: FP_REG_W]) chk_hit[k] = 1'b1;
                end
            end
        end
    end

    // Head/tail pointers; flush returns both to channel 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_head <= '0;
            r_tail <= '0;
        end else if (flush) begin
            r_head <= '0;
            r_tail <= '0;
        end else begin
            if (w_accept) r_tail <= ptr_inc(r_tail);
            if (w_retire) r_head <= ptr_inc(r_head);
        end
    end

endmodule

// File: tb/tb_fpu_slow_dispatch.sv
// tb_fpu_slow_dispatch: directed, table-driven bench for fpu_slow_dispatch (N_CH=2, N_CHK=3,
// default build without FPU_SLOW_DISPATCH_BYPASS_EN).
module tb_fpu_slow_dispatch;

    logic        clk = 1'b0;
    logic        rst;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic        issue_ready;
    logic [1:0]  ch_en;
    logic [1:0]  ch_valid;
    logic [63:0] ch_result;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        wb_ready;
    logic        flush;
    logic [14:0] chk_rd;
    logic [2:0]  chk_hit;
    logic [1:0]  inflight;

    always #5 clk = ~clk;

    fpu_slow_dispatch #(.N_CH(2), .N_CHK(3)) dut (
        .clk         (clk),
        .rst         (rst),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .issue_ready (issue_ready),
        .ch_en       (ch_en),
        .ch_valid    (ch_valid),
        .ch_result   (ch_result),
        .wb_valid    (wb_valid),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
        .wb_ready    (wb_ready),
        .flush       (flush),
        .chk_rd      (chk_rd),
        .chk_hit     (chk_hit),
        .inflight    (inflight)
    );

    typedef struct {
        logic        rn;
        logic        iv;
        logic [4:0]  ird;
        logic [1:0]  cv;
        logic [31:0] r0;
        logic [31:0] r1;
        logic        wbr;
        logic        fl;
        logic [14:0] chk;
        logic        e_ir;
        logic [1:0]  e_en;
        logic        e_wbv;
        logic [4:0]  e_wbrd;
        logic [31:0] e_wbd;
        logic [2:0]  e_hit;
        logic [1:0]  e_inf;
    } vec_t;

    // chk ports: {port2, port1, port0}
    localparam logic [14:0] CHK_A = {5'd3, 5'd5, 5'd1};
    localparam logic [14:0] CHK_B = {5'd6, 5'd4, 5'd0};
    localparam logic [31:0] R1 = 32'h3F80_0000;
    localparam logic [31:0] R2 = 32'h4000_0000;
    localparam logic [31:0] R3 = 32'h4040_0000;

    int   total = 0;
    int   bad   = 0;
    vec_t tbl[$];

    function automatic vec_t mk(
        input logic rn, input logic iv, input logic [4:0] ird, input logic [1:0] cv,
        input logic [31:0] r0, input logic [31:0] r1, input logic wbr, input logic fl,
        input logic [14:0] chk, input logic e_ir, input logic [1:0] e_en, input logic e_wbv,
        input logic [4:0] e_wbrd, input logic [31:0] e_wbd, input logic [2:0] e_hit,
        input logic [1:0] e_inf);
        vec_t v;
        v.rn = rn; v.iv = iv; v.ird = ird; v.cv = cv; v.r0 = r0; v.r1 = r1;
        v.wbr = wbr; v.fl = fl; v.chk = chk;
        v.e_ir = e_ir; v.e_en = e_en; v.e_wbv = e_wbv; v.e_wbrd = e_wbrd;
        v.e_wbd = e_wbd; v.e_hit = e_hit; v.e_inf = e_inf;
        return v;
    endfunction

    task automatic cmp(input string nm, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s step %0d: got %h want %h", nm, idx, act, exp);
        end
    endtask

    // Drive one cycle of inputs at the falling edge, check outputs before the next rising edge.
    task automatic step(input vec_t v, input int idx);
        @(negedge clk);
        rst         = v.rn;
        issue_valid = v.iv;
        issue_rd    = v.ird;
        ch_valid    = v.cv;
        ch_result   = {v.r1, v.r0};
        wb_ready    = v.wbr;
        flush       = v.fl;
        chk_rd      = v.chk;
        #1;
        cmp("issue_ready", idx, 32'(issue_ready), 32'(v.e_ir));
        cmp("ch_en",       idx, 32'(ch_en),       32'(v.e_en));
        cmp("wb_valid",    idx, 32'(wb_valid),    32'(v.e_wbv));
        cmp("wb_rd",       idx, 32'(wb_rd),       32'(v.e_wbrd));
        cmp("wb_data",     idx, wb_data,          v.e_wbd);
        cmp("chk_hit",     idx, 32'(chk_hit),     32'(v.e_hit));
        cmp("inflight",    idx, 32'(inflight),    32'(v.e_inf));
    endtask

    initial begin
        rst = 1'b0; issue_valid = 1'b0; issue_rd = '0; ch_valid = '0; ch_result = '0;
        wb_ready = 1'b0; flush = 1'b0; chk_rd = '0;

        // Reset: everything quiet even with issue_valid and ch_valid driven.
        tbl.push_back(mk(0,1,5'd3,2'b01,R1,0,1,0,CHK_A, 0,2'b00,0,5'd0,0,3'b000,2'd0));
        tbl.push_back(mk(0,0,5'd0,2'b00,0,0,1,0,CHK_A,  0,2'b00,0,5'd0,0,3'b000,2'd0));
        // Single op rd=3 on ch0, result four cycles later, writeback one cycle after.
        tbl.push_back(mk(1,1,5'd3,2'b00,0,0,1,0,CHK_A,  1,2'b01,0,5'd0,0,3'b000,2'd0));
        tbl.push_back(mk(1,0,5'd0,2'b00,0,0,1,0,CHK_A,  1,2'b00,0,5'd0,0,3'b100,2'd1));
        tbl.push_back(mk(1,0,5'd0,2'b00,0,0,1,0,CHK_A,  1,2'b00,0,5'd0,0,3'b100,2'd1));
        tbl.push_back(mk(1,0,5'd0,2'b00,0,0,1,0,CHK_A,  1,2'b00,0,5'd0,0,3'b100,2'd1));
        tbl.push_back(mk(1,0,5'd0,2'b01,R1,0,1,0,CHK_A, 1,2'b00,0,5'd0,0,3'b100,2'd1));
        tbl.push_back(mk(1,0,5'd0,2'b00,0,0,1,0,CHK_A,  1,2'b00,1,5'd3,R1,3'b100,2'd1));
        tbl.push_back(mk(1,0,5'd0,2'b00,0,0,1,0,CHK_A,  1,2'b00,0,5'd0,0,3'b000,2'd0));
        // Reset with pointers at 1 brings them back to 0.
        tbl.push_back(mk(0,1,5'd7,2'b00,0,0,1,0,CHK_A,  0,2'b00,0,5'd0,0,3'b000,2'd0));
        // rd=1 on ch0, rd=2 on ch1, third issue refused while both busy.
        tbl.push_back(mk(1,1,5'd1,2'b00,0,0,1,0,CHK_A,  1,2'b01,0,5'd0,0,3'b000,2'd0));
        tbl.push_back(mk(1,1,5'd2,2'b00,0,0,1,0,CHK_A,  1,2'b10,0,5'd0,0,3'b001,2'd1));
        tbl.push_back(mk(1,1,5'd9,2'b00,0,0,1,0,CHK_A,  0,2'b00,0,5'd0,0,3'b001,2'd2));
        // ch1 completes first; nothing retires while head ch0 is still busy.
        tbl.push_back(mk(1,0,5'd0,2'b10,0,R2,1,0,CHK_A, 0,2'b00,0,5'd0,0,3'b001,2'd2));
        tbl.push_back(mk(1,0,5'd0,2'b00,0,0,1,0,CHK_A,  0,2'b00,0,5'd0,0,3'b001,2'd2));
        tbl.push_back(mk(1,0,5'd0,2'b01,R3,0,1,0,CHK_A, 0,2'b00,0,5'd0,0,3'b001,2'd2));
        // Writeback stalled three cycles: rd=1 held stable.
        tbl.push_back(mk(1,0,5'd0,2'b00,0,0,0,0,CHK_A,  0,2'b00,1,5'd1,R3,3'b001,2'd2));
        tbl.push_back(mk(1,0,5'd0,2'b00,0,0,0,0,CHK_A,  0,2'b00,1,5'd1,R3,3'b001,2'd2));
        tbl.push_back(mk(1,0,5'd0,2'b00,0,0,0,0,CHK_A,  0,2'b00,1,5'd1,R3,3'b001,2'd2));
        tbl.push_back(mk(1,0,5'd0,2'b00,0,0,1,0,CHK_A,  0,2'b00,1,5'd1,R3,3'b001,2'd2));
        // rd=2 retires while a new op issues into freshly freed ch0.
        tbl.push_back(mk(1,1,5'd4,2'b00,0,0,1,0,CHK_A,  1,2'b01,1,5'd2,R2,3'b000,2'd1));
        tbl.push_back(mk(1,0,5'd0,2'b00,0,0,1,0,CHK_A,  1,2'b00,0,5'd0,0,3'b000,2'd1));

        for (int i = 0; i < tbl.size(); i++) step(tbl[i], i);

        // Flush with ch0 busy (rd=4): issue blocked, pointers to 0, drain until ch_valid[0].
        step(mk(1,1,5'd6,2'b00,0,0,1,1,CHK_B, 0,2'b00,0,5'd0,0,3'b010,2'd1), 100);
        step(mk(1,1,5'd6,2'b00,0,0,1,0,CHK_B, 0,2'b00,0,5'd0,0,3'b000,2'd0), 101);
        step(mk(1,1,5'd6,2'b00,0,0,1,0,CHK_B, 0,2'b00,0,5'd0,0,3'b000,2'd0), 102);
        step(mk(1,1,5'd6,2'b01,32'hDEADBEEF,0,1,0,CHK_B, 0,2'b00,0,5'd0,0,3'b000,2'd0), 103);
        step(mk(1,0,5'd0,2'b00,0,0,1,0,CHK_B, 1,2'b00,0,5'd0,0,3'b000,2'd0), 104);
        step(mk(1,1,5'd6,2'b00,0,0,1,0,CHK_B, 1,2'b01,0,5'd0,0,3'b000,2'd0), 105);
        step(mk(1,0,5'd0,2'b01,32'h12345678,0,1,0,CHK_B, 1,2'b00,0,5'd0,0,3'b100,2'd1), 106);
        step(mk(1,0,5'd0,2'b00,0,0,1,0,CHK_B, 1,2'b00,1,5'd6,32'h12345678,3'b100,2'd1), 107);
        step(mk(1,0,5'd0,2'b00,0,0,1,0,CHK_B, 1,2'b00,0,5'd0,0,3'b000,2'd0), 108);

        // Reset with ch1 busy on f0; the late ch_valid[1] must be ignored.
        step(mk(1,1,5'd0,2'b00,0,0,1,0,CHK_B, 1,2'b10,0,5'd0,0,3'b000,2'd0), 200);
        step(mk(1,0,5'd0,2'b00,0,0,1,0,CHK_B, 1,2'b00,0,5'd0,0,3'b001,2'd1), 201);
        step(mk(0,0,5'd0,2'b00,0,0,1,0,CHK_B, 0,2'b00,0,5'd0,0,3'b000,2'd0), 202);
        step(mk(1,0,5'd0,2'b10,0,32'hCAFEF00D,1,0,CHK_B, 1,2'b00,0,5'd0,0,3'b000,2'd0), 203);
        step(mk(1,0,5'd0,2'b00,0,0,1,0,CHK_B, 1,2'b00,0,5'd0,0,3'b000,2'd0), 204);
        step(mk(1,1,5'd5,2'b00,0,0,1,0,CHK_B, 1,2'b01,0,5'd0,0,3'b000,2'd0), 205);

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
